fp_unit_arbiter: RTL and testbench
==================================

Name: fp_unit_arbiter

Overview:
- Shares one multi-cycle FP execution unit between two requesters (e.g. host port and DMA/vector port).
- Round-robin arbitration; the winner's operands, mode and opcode are latched, then one start pulse is issued to the unit.
- The block waits for the unit's done pulse, guarded by a watchdog, and returns result and flags to the granted requester over a valid/ready response channel.
- Sits between the requester ports and the FP decode/execute datapath; the datapath receives 32-bit operands plus MODE_FP (0 = half, 1 = single).

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles spent in WAIT before the watchdog aborts the operation; legal range 2..65535.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): width of the watchdog counter (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op_a, req0_op_b  in  32  operands; half mode uses bits [15:0].
- req0_mode_fp  in  1  0 = half, 1 = single.
- req0_opcode  in  2  operation code, passed through to the unit unchanged.
- req1_valid / req1_ready / req1_op_a / req1_op_b / req1_mode_fp / req1_opcode: same as requester 0.
- resp0_valid  out  1  result available for requester 0.
- resp0_ready  in  1  requester 0 takes the result.
- resp0_result  out  32  result value.
- resp0_flags  out  5  {invalid, div0, overflow, underflow, inexact}.
- resp1_valid / resp1_ready / resp1_result / resp1_flags: same as requester 0.
- eu_start  out  1  one-cycle start pulse to the execution unit.
- eu_op_a, eu_op_b  out  32  latched operands.
- eu_mode_fp  out  1  latched mode.
- eu_opcode  out  2  latched opcode.
- eu_done  in  1  one-cycle completion pulse from the unit.
- eu_result  in  32  unit result, valid with eu_done.
- eu_flags  in  5  unit flags, valid with eu_done.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n = 0):
  - State is IDLE; round-robin pointer rr = 0 (requester 0 has priority).
  - All outputs are 0: ready, resp_valid, result, flags, all eu_* outputs, busy.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant rule: if exactly one reqN_valid is high, grant N. If both are high, grant rr.
  - reqN_ready is asserted combinationally in the same cycle, only for the granted requester. Accepting does not depend on reqN_ready being observed.
  - On grant, latch op_a, op_b, mode_fp and opcode into the eu_* registers, record the grant id, and go to ISSUE.
  - No valid: stay in IDLE.
- ISSUE:
  - eu_start = 1 for exactly one cycle; clear the watchdog counter; go to WAIT.
  - eu_done is ignored in this state.
- WAIT:
  - On eu_done = 1: latch result and flags, then go to RESP.
  - In half mode the latched result has bits [31:16] forced to 0.
  - Otherwise increment the counter. When it reaches TIMEOUT_CYCLES, load the canonical quiet NaN (single 32'h7FC00000, half 32'h00007E00) with flags 5'b10000, then go to RESP.
  - If eu_done arrives in the same cycle the counter reaches the limit, eu_done wins.
- RESP:
  - respG_valid = 1 with the latched result and flags held stable until respG_ready = 1.
  - On the handshake cycle: rr = the other requester, then go to IDLE.
  - The non-granted resp_valid stays 0.
  - eu_done seen outside WAIT is ignored.
- Latency:
  - Accept at cycle T, eu_start at T+1.
  - eu_done is sampled no earlier than T+2.
  - resp_valid is asserted the cycle after eu_done.
  - Minimum accept-to-response latency is 3 cycles.
- Throughput: one operation in flight. The earliest next acceptance is the cycle after the response handshake.
- Starvation: alternating rr guarantees each requester is served at least every second operation.
- eu_* operand, mode and opcode outputs hold their value after ISSUE until the next grant.
- Reset mid-operation: abort immediately and return to the reset values. A late eu_done after reset is ignored because the FSM is in IDLE.
- Back-pressure: resp_ready held low keeps the FSM in RESP indefinitely; no further requests are accepted.

Decomposition:
- Shared package fp_pkg holds:
  - State enum (IDLE, ISSUE, WAIT, RESP).
  - Flag bit positions.
  - Canonical NaN constants QNAN_SINGLE and QNAN_HALF.
  - MODE_HALF = 0 and MODE_SINGLE = 1.
- One natural sub-module, rr_arbiter2: 2-input round-robin grant logic with a pointer-update input. The FSM, latches and watchdog stay in fp_unit_arbiter.

Test Plan:
- Single request: req0 with op_a = 32'h3F800000, op_b = 32'h40000000, mode = 1; unit returns 32'h40400000, flags 0 after 3 cycles -> req0_ready for 1 cycle, one eu_start pulse, resp0_valid with 32'h40400000, resp1_valid stays 0.
- Simultaneous valid from reset: req0 and req1 both valid -> req0 served first, req1 next. Then both valid again -> req0 served (rr alternates: 0, 1, 0).
- Half mode: req1 with mode = 0, op_a = 32'hABCD3C00; unit returns 32'hFFFF4000 -> eu_op_a = 32'hABCD3C00 passed through; resp1_result = 32'h00004000.
- Timeout: TIMEOUT_CYCLES = 8, unit never asserts done -> resp_valid after 8 WAIT cycles with 32'h7FC00000 (single) or 32'h00007E00 (half), flags 5'b10000.
- Back-pressure and stray done: resp0_ready held low for 10 cycles with a spurious eu_done in RESP -> result stable, no new ready, busy = 1. Extra eu_done pulses while IDLE -> no response generated.
- Async reset in WAIT: rst_n low mid-operation -> all outputs 0 immediately. A late eu_done after release -> no response; the next request is granted normally.

Source files
------------

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types and constants for the FP unit arbiter
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int FLAG_INVALID   = 4;
    localparam int FLAG_DIV0      = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    localparam logic [4:0]  FLAGS_TIMEOUT = 5'(1 << FLAG_INVALID);
    localparam logic [31:0] QNAN_SINGLE   = 32'h7FC0_0000;
    localparam logic [31:0] QNAN_HALF     = 32'h0000_7E00;

    localparam logic MODE_HALF   = 1'b0;
    localparam logic MODE_SINGLE = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester round-robin grant with pointer update
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       advance,
    input  logic       served,
    output logic       grant_valid,
    output logic       grant_id
);

    logic rr;

    // Pointer only moves on a completed response so the loser keeps priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr <= 1'b0;
        end else if (advance) begin
            rr <= ~served;
        end
    end

    assign grant_valid = |valid;
    assign grant_id    = (valid == 2'b11) ? rr : valid[1];

endmodule

// File: rtl/fp_unit_arbiter.sv
// rtl/fp_unit_arbiter.sv - shares one multi-cycle FP unit between two requesters
module fp_unit_arbiter
    import fp_pkg::*;
#(
    parameter  int TIMEOUT_CYCLES = 64,
    localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_op_a,
    input  logic [31:0] req0_op_b,
    input  logic        req0_mode_fp,
    input  logic [1:0]  req0_opcode,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_op_a,
    input  logic [31:0] req1_op_b,
    input  logic        req1_mode_fp,
    input  logic [1:0]  req1_opcode,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic [31:0] resp0_result,
    output logic [4:0]  resp0_flags,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [31:0] resp1_result,
    output logic [4:0]  resp1_flags,
    output logic        eu_start,
    output logic [31:0] eu_op_a,
    output logic [31:0] eu_op_b,
    output logic        eu_mode_fp,
    output logic [1:0]  eu_opcode,
    input  logic        eu_done,
    input  logic [31:0] eu_result,
    input  logic [4:0]  eu_flags,
    output logic        busy
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    logic             gid;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [31:0]      res_q;
    logic [4:0]       flags_q;
    logic             grant_valid;
    logic             grant_id;
    logic             accept;
    logic             resp_hs;

    rr_arbiter2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid       ({req1_valid, req0_valid}),
        .advance     (resp_hs),
        .served      (gid),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Gated by rst_n so ready stays low while reset is held.
    assign accept     = rst_n && (state == IDLE) && grant_valid;
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;

    assign resp_hs     = (state == RESP) && (gid ? resp1_ready : resp0_ready);
    assign resp0_valid = (state == RESP) && !gid;
    assign resp1_valid = (state == RESP) && gid;
    assign resp0_result = res_q;
    assign resp1_result = res_q;
    assign resp0_flags  = flags_q;
    assign resp1_flags  = flags_q;
    assign busy         = (state != IDLE);
    assign cnt_inc      = cnt + CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gid        <= 1'b0;
            cnt        <= '0;
            res_q      <= '0;
            flags_q    <= '0;
            eu_start   <= 1'b0;
            eu_op_a    <= '0;
            eu_op_b    <= '0;
            eu_mode_fp <= 1'b0;
            eu_opcode  <= '0;
        end else begin
            eu_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        gid        <= grant_id;
                        eu_op_a    <= grant_id ? req1_op_a    : req0_op_a;
                        eu_op_b    <= grant_id ? req1_op_b    : req0_op_b;
                        eu_mode_fp <= grant_id ? req1_mode_fp : req0_mode_fp;
                        eu_opcode  <= grant_id ? req1_opcode  : req0_opcode;
                        eu_start   <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the limit cycle still delivers the real result.
                    if (eu_done) begin
                        res_q   <= (eu_mode_fp == MODE_SINGLE) ? eu_result
                                                               : {16'h0000, eu_result[15:0]};
                        flags_q <= eu_flags;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc == CNT_LIMIT) begin
                            res_q   <= (eu_mode_fp == MODE_SINGLE) ? QNAN_SINGLE : QNAN_HALF;
                            flags_q <= FLAGS_TIMEOUT;
                            state   <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (resp_hs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// tb/tb_fp_unit_arbiter.sv - randomized self-checking bench for fp_unit_arbiter
module tb_fp_unit_arbiter;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_mode_fp;
    logic [31:0] req0_op_a, req0_op_b;
    logic [1:0]  req0_opcode;
    logic        req1_valid, req1_ready, req1_mode_fp;
    logic [31:0] req1_op_a, req1_op_b;
    logic [1:0]  req1_opcode;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [31:0] resp0_result, resp1_result;
    logic [4:0]  resp0_flags, resp1_flags;
    logic        eu_start, eu_mode_fp, eu_done, busy;
    logic [31:0] eu_op_a, eu_op_b, eu_result;
    logic [1:0]  eu_opcode;
    logic [4:0]  eu_flags;

    int   vectors = 0;
    int   miscompares = 0;
    logic rr_m = 1'b0;

    logic [31:0] opa [2];
    logic [31:0] opb [2];
    logic        md  [2];
    logic [1:0]  oc  [2];

    always #5 clk = ~clk;

    fp_unit_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op_a(req0_op_a),
        .req0_op_b(req0_op_b), .req0_mode_fp(req0_mode_fp), .req0_opcode(req0_opcode),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op_a(req1_op_a),
        .req1_op_b(req1_op_b), .req1_mode_fp(req1_mode_fp), .req1_opcode(req1_opcode),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
        .resp0_flags(resp0_flags), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp1_result(resp1_result), .resp1_flags(resp1_flags),
        .eu_start(eu_start), .eu_op_a(eu_op_a), .eu_op_b(eu_op_b), .eu_mode_fp(eu_mode_fp),
        .eu_opcode(eu_opcode), .eu_done(eu_done), .eu_result(eu_result), .eu_flags(eu_flags),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic m, input logic [1:0] c);
        opa[idx] = a; opb[idx] = b; md[idx] = m; oc[idx] = c;
    endtask

    task automatic rand_req(input int idx);
        set_req(idx, $urandom, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    endtask

    // One full transaction; delay = WAIT cycle carrying eu_done (> TMO means never).
    task automatic do_op(input logic v0, input logic v1, input int delay, input int bp,
                         input bit stray, input logic [31:0] res, input logic [4:0] fl);
        logic        w;
        logic [31:0] exp_res;
        logic [4:0]  exp_fl;
        w = (v0 && v1) ? rr_m : v1;
        if (delay > TMO) begin
            exp_res = md[w] ? 32'h7FC0_0000 : 32'h0000_7E00;
            exp_fl  = 5'b10000;
        end else begin
            exp_res = md[w] ? res : (res & 32'h0000_FFFF);
            exp_fl  = fl;
        end

        @(negedge clk);
        req0_valid = v0; req0_op_a = opa[0]; req0_op_b = opb[0];
        req0_mode_fp = md[0]; req0_opcode = oc[0];
        req1_valid = v1; req1_op_a = opa[1]; req1_op_b = opb[1];
        req1_mode_fp = md[1]; req1_opcode = oc[1];
        #1;
        chkb("req0_ready_grant", req0_ready, v0 && !w);
        chkb("req1_ready_grant", req1_ready, v1 && w);
        chkb("busy_idle", busy, 1'b0);

        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chkb("eu_start_issue", eu_start, 1'b1);
        chk("eu_op_a", eu_op_a, opa[w]);
        chk("eu_op_b", eu_op_b, opb[w]);
        chkb("eu_mode_fp", eu_mode_fp, md[w]);
        chk("eu_opcode", 32'(eu_opcode), 32'(oc[w]));
        chkb("busy_issue", busy, 1'b1);

        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk);
            eu_done   = (k == delay);
            eu_result = (k == delay) ? res : $urandom;
            eu_flags  = (k == delay) ? fl  : 5'($urandom);
            #1;
            chkb("eu_start_wait", eu_start, 1'b0);
            chkb("resp_valid_wait", w ? resp1_valid : resp0_valid, 1'b0);
            if (k == delay) break;
        end

        @(negedge clk);
        eu_done = 1'b0; eu_result = $urandom;
        #1;
        chkb("resp_valid_w", w ? resp1_valid : resp0_valid, 1'b1);
        chkb("resp_valid_other", w ? resp0_valid : resp1_valid, 1'b0);
        chk("resp_result", w ? resp1_result : resp0_result, exp_res);
        chk("resp_flags", 32'(w ? resp1_flags : resp0_flags), 32'(exp_fl));

        for (int i = 0; i < bp; i++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            eu_done = stray && (i == 0);
            eu_result = $urandom;
            #1;
            chkb("bp_ready0", req0_ready, 1'b0);
            chkb("bp_ready1", req1_ready, 1'b0);
            chkb("bp_busy", busy, 1'b1);
            chkb("bp_valid", w ? resp1_valid : resp0_valid, 1'b1);
            chk("bp_result", w ? resp1_result : resp0_result, exp_res);
            chk("bp_hold_op_a", eu_op_a, opa[w]);
            @(negedge clk);
        end

        req0_valid = 1'b0; req1_valid = 1'b0; eu_done = 1'b0;
        if (w) resp1_ready = 1'b1; else resp0_ready = 1'b1;
        #1;
        chk("hs_result", w ? resp1_result : resp0_result, exp_res);
        @(negedge clk);
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        #1;
        chkb("post_hs_valid", w ? resp1_valid : resp0_valid, 1'b0);
        chkb("post_hs_busy", busy, 1'b0);
        rr_m = ~w;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 0; req0_op_a = 0; req0_op_b = 0; req0_mode_fp = 0; req0_opcode = 0;
        req1_valid = 0; req1_op_a = 0; req1_op_b = 0; req1_mode_fp = 0; req1_opcode = 0;
        resp0_ready = 0; resp1_ready = 0;
        eu_done = 0; eu_result = 0; eu_flags = 0;
        repeat (2) @(negedge clk);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_eu_start", eu_start, 1'b0);
        chk("rst_eu_op_a", eu_op_a, 32'h0);
        chkb("rst_resp0_valid", resp0_valid, 1'b0);
        chk("rst_resp1_result", resp1_result, 32'h0);
        rst_n = 1'b1;

        set_req(0, 32'h3F80_0000, 32'h4000_0000, 1'b1, 2'd0);
        set_req(1, 32'h0, 32'h0, 1'b0, 2'd0);
        do_op(1, 0, 3, 0, 0, 32'h4040_0000, 5'b0);

        set_req(1, 32'hABCD_3C00, 32'h1234_4000, 1'b0, 2'd2);
        do_op(0, 1, 2, 0, 0, 32'hFFFF_4000, 5'b00001);

        set_req(0, 32'h1111_1111, 32'h2222_2222, 1'b1, 2'd1);
        do_op(1, 0, TMO + 5, 0, 0, 32'h0, 5'b0);
        set_req(1, 32'h3333_3333, 32'h4444_4444, 1'b0, 2'd3);
        do_op(0, 1, TMO + 5, 0, 0, 32'h0, 5'b0);
        do_op(0, 1, TMO, 0, 0, 32'h5555_6666, 5'b00100);
        do_op(1, 0, 1, 0, 0, 32'h7777_8888, 5'b01000);

        do_op(1, 0, 2, 10, 1, 32'h9999_AAAA, 5'b00010);

        repeat (3) begin
            @(negedge clk);
            eu_done = 1'b1; eu_result = $urandom;
            #1;
            chkb("idle_stray_resp0", resp0_valid, 1'b0);
            chkb("idle_stray_resp1", resp1_valid, 1'b0);
            chkb("idle_stray_busy", busy, 1'b0);
        end
        @(negedge clk);
        eu_done = 1'b0;

        @(negedge clk);
        req0_valid = 1'b1; req0_op_a = 32'hDEAD_BEEF; req0_mode_fp = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0; req0_valid = 1'b1;
        #1;
        chkb("arst_busy", busy, 1'b0);
        chkb("arst_ready", req0_ready, 1'b0);
        chk("arst_eu_op_a", eu_op_a, 32'h0);
        chkb("arst_eu_mode", eu_mode_fp, 1'b0);
        chkb("arst_resp0", resp0_valid, 1'b0);
        @(negedge clk);
        req0_valid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        eu_done = 1'b1; eu_result = 32'hCAFE_F00D;
        @(negedge clk);
        eu_done = 1'b0;
        #1;
        chkb("late_done_resp0", resp0_valid, 1'b0);
        chkb("late_done_busy", busy, 1'b0);
        rr_m = 1'b0;

        rand_req(0); rand_req(1);
        do_op(1, 1, 3, 0, 0, 32'h0102_0304, 5'b0);
        rand_req(0); rand_req(1);
        do_op(1, 1, 2, 1, 0, 32'h0506_0708, 5'b0);
        rand_req(0); rand_req(1);
        do_op(1, 1, 4, 0, 0, 32'h090A_0B0C, 5'b0);

        for (int n = 0; n < 30; n++) begin
            int vv;
            vv = $urandom_range(1, 3);
            rand_req(0); rand_req(1);
            do_op(vv[0], vv[1], $urandom_range(1, TMO + 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), $urandom, 5'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
